imem_dmem_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (1-cycle read latency) between the instruction-fetch port and the load/store port of the pipelined core.
- Replaces separate imem/dmem arrays so program and data live in one BRAM.
- Grants one access per cycle, steers the registered read data back to the owner, and reports fetch-stall cycles.
- Data side has priority, with an anti-starvation guard for fetch.

---
 rtl/imem_dmem_arbiter_pkg.sv | 16 +
 rtl/imem_dmem_arbiter.sv | 84 ++++++++
 tb/tb_imem_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the instruction/data port arbiter on the unified RAM.
package imem_dmem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF      = 16;
    localparam int unsigned MAX_D_BURST_DEF = 4;
    localparam int unsigned BURST_W         = 4;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned MASK_W          = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_t;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port RAM, data first,
// with a bounded data burst so a waiting fetch is eventually forced through.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned MAX_D_BURST = MAX_D_BURST_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [MASK_W-1:0]   d_wmask,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                ram_en,
    output logic [ADDR_W-3:0]   ram_addr,
    output logic [MASK_W-1:0]   ram_wmask,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [31:0]         fetch_stall_cnt
);

    owner_t             owner_q, owner_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               force_i;
    logic               unused_addr_bits;

    // Word-aligned RAM ignores the byte offset of both ports.
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // Grant, RAM steering and next owner / burst state.
    always_comb begin
        force_i   = i_req && (burst_q == BURST_W'(MAX_D_BURST));
        d_gnt     = resetn && d_req && !force_i;
        i_gnt     = resetn && i_req && !d_gnt;
        ram_en    = i_gnt || d_gnt;
        ram_addr  = d_gnt ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
        ram_wmask = d_gnt ? d_wmask : '0;
        ram_wdata = d_wdata;

        owner_d = OWN_NONE;
        if (i_gnt) begin
            owner_d = OWN_I;
        end else if (d_gnt && (d_wmask == '0)) begin
            owner_d = OWN_D;
        end

        burst_d = burst_q;
        if (i_gnt || !i_req) begin
            burst_d = '0;
        end else if (d_gnt && (burst_q < BURST_W'(MAX_D_BURST))) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_q         <= OWN_NONE;
            burst_q         <= '0;
            fetch_stall_cnt <= '0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
            if (i_req && !i_gnt) begin
                fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
            end
        end
    end

    // Read data is shared; only the owner's rvalid qualifies it.
    assign i_rvalid = (owner_q == OWN_I);
    assign d_rvalid = (owner_q == OWN_D);
    assign i_rdata  = ram_rdata;
    assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Randomized and directed bench for imem_dmem_arbiter against a transaction-level model.
module tb_imem_dmem_arbiter;

    localparam int ADDR_W = 16;
    localparam int MAX_B  = 4;
    localparam int WORDS  = 1024;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, d_req;
    logic [15:0] i_addr, d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, ram_en;
    logic [31:0] i_rdata, d_rdata, ram_wdata, ram_rdata, fetch_stall_cnt;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wmask;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: fetch wait length in data grants, stall total, expected read.
    int          m_burst;
    int unsigned m_stall;
    int          pend;
    logic [31:0] pdata;
    logic [31:0] shadow [0:WORDS-1];

    // RAM fixture
    logic [31:0] ram [0:WORDS-1];
    logic        ram_loaded = 1'b0;

    always #5 clk = ~clk;

    imem_dmem_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wmask(ram_wmask), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .fetch_stall_cnt(fetch_stall_cnt)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'h9E3779B9 * 32'(i + 1);
    endfunction

    function automatic int widx(logic [15:0] a);
        return int'(a[11:2]);
    endfunction

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wmask[b]) ram[ram_addr[9:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= ram[ram_addr[9:0]];
        end
    end

    // One clock of stimulus: checks grants mid-cycle, advances the model, checks results.
    task automatic do_cycle(output logic gi, output logic gd);
        logic egi, egd, frc;
        @(negedge clk);
        if (!resetn) begin
            egi = 1'b0; egd = 1'b0;
        end else begin
            frc = i_req && (m_burst == MAX_B);
            egd = d_req && !frc;
            egi = i_req && !egd;
        end
        n_tests++;
        if (i_gnt !== egi) begin n_fail++; $display("FAIL i_gnt: got %b expected %b", i_gnt, egi); end
        n_tests++;
        if (d_gnt !== egd) begin n_fail++; $display("FAIL d_gnt: got %b expected %b", d_gnt, egd); end
        n_tests++;
        if (ram_en !== (egi || egd)) begin n_fail++; $display("FAIL ram_en: got %b expected %b", ram_en, egi || egd); end
        if (egi || egd) begin
            n_tests++;
            if (ram_addr !== (egd ? d_addr[15:2] : i_addr[15:2])) begin
                n_fail++; $display("FAIL ram_addr: got %0h expected %0h", ram_addr, egd ? d_addr[15:2] : i_addr[15:2]);
            end
            n_tests++;
            if (ram_wmask !== (egd ? d_wmask : 4'b0)) begin
                n_fail++; $display("FAIL ram_wmask: got %b expected %b", ram_wmask, egd ? d_wmask : 4'b0);
            end
        end
        if (egd && d_wmask != 4'b0) begin
            n_tests++;
            if (ram_wdata !== d_wdata) begin n_fail++; $display("FAIL ram_wdata: got %h expected %h", ram_wdata, d_wdata); end
        end
        if (!resetn) begin
            m_burst = 0; m_stall = 0; pend = 0;
        end else begin
            pend = 0;
            if (egi) begin
                pend = 1; pdata = shadow[widx(i_addr)];
            end else if (egd) begin
                if (d_wmask == 4'b0) begin
                    pend = 2; pdata = shadow[widx(d_addr)];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (d_wmask[b]) shadow[widx(d_addr)][b*8 +: 8] = d_wdata[b*8 +: 8];
                end
            end
            if (i_req && !egi) m_stall++;
            if (egi || !i_req) m_burst = 0;
            else if (egd && m_burst < MAX_B) m_burst++;
        end
        @(posedge clk); #1;
        n_tests++;
        if (i_rvalid !== (pend == 1)) begin n_fail++; $display("FAIL i_rvalid: got %b expected %b", i_rvalid, pend == 1); end
        n_tests++;
        if (d_rvalid !== (pend == 2)) begin n_fail++; $display("FAIL d_rvalid: got %b expected %b", d_rvalid, pend == 2); end
        if (pend == 1) begin
            n_tests++;
            if (i_rdata !== pdata) begin n_fail++; $display("FAIL i_rdata: got %h expected %h", i_rdata, pdata); end
        end
        if (pend == 2) begin
            n_tests++;
            if (d_rdata !== pdata) begin n_fail++; $display("FAIL d_rdata: got %h expected %h", d_rdata, pdata); end
        end
        n_tests++;
        if (fetch_stall_cnt !== m_stall) begin
            n_fail++; $display("FAIL fetch_stall_cnt: got %0d expected %0d", fetch_stall_cnt, m_stall);
        end
        gi = egi; gd = egd;
    endtask

    task automatic idle_reqs();
        i_req = 1'b0; d_req = 1'b0; d_wmask = 4'b0; d_wdata = 32'h0;
    endtask

    task automatic apply_reset();
        logic gi, gd;
        resetn = 1'b0;
        idle_reqs();
        do_cycle(gi, gd);
        do_cycle(gi, gd);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic gi, gd;
        resetn = 1'b0;
        i_req = 1'b1; i_addr = 16'h0; d_req = 1'b1; d_addr = 16'h0; d_wmask = 4'b0; d_wdata = 32'h0;
        repeat (3) do_cycle(gi, gd);
        n_tests++;
        if (fetch_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", fetch_stall_cnt); end
        idle_reqs();
        resetn = 1'b1;
    endtask

    task automatic test_fetch_seq();
        logic gi, gd;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            i_req = 1'b1; i_addr = 16'(k * 4);
            do_cycle(gi, gd);
            n_tests++;
            if (gi !== 1'b1 || i_rdata !== init_word(k)) begin
                n_fail++; $display("FAIL fetch_seq: got gnt %b data %h expected 1 %h", gi, i_rdata, init_word(k));
            end
        end
        i_req = 1'b0;
        n_tests++;
        if (fetch_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL fetch_seq_stall: got %0d expected 0", fetch_stall_cnt); end
    endtask

    task automatic test_priority();
        logic gi, gd;
        apply_reset();
        i_req = 1'b1; i_addr = 16'h0020;
        d_req = 1'b1; d_addr = 16'h0100; d_wmask = 4'b0;
        do_cycle(gi, gd);
        n_tests++;
        if (gd !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== shadow[64]) begin
            n_fail++; $display("FAIL priority_d: got gnt %b rvalid %b data %h expected 1 1 %h", gd, d_rvalid, d_rdata, shadow[64]);
        end
        d_req = 1'b0;
        do_cycle(gi, gd);
        i_req = 1'b0;
        n_tests++;
        if (gi !== 1'b1 || fetch_stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL priority_i: got gnt %b stall %0d expected 1 1", gi, fetch_stall_cnt);
        end
    endtask

    task automatic test_burst();
        logic gi, gd;
        logic [7:0] seq;
        apply_reset();
        seq = 8'h0;
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_wmask = 4'b0;
        for (int k = 0; k < 8; k++) begin
            d_addr = 16'(16'h0200 + k * 4);
            do_cycle(gi, gd);
            seq[k] = gi;
            if (gi) i_addr = i_addr + 16'd4;
        end
        idle_reqs();
        n_tests++;
        if (seq !== 8'b0001_0000) begin n_fail++; $display("FAIL burst_seq: got %b expected %b", seq, 8'b0001_0000); end
        n_tests++;
        if (fetch_stall_cnt !== 32'd7) begin n_fail++; $display("FAIL burst_stall: got %0d expected 7", fetch_stall_cnt); end
    endtask

    task automatic test_store();
        logic gi, gd;
        apply_reset();
        d_req = 1'b1; d_addr = 16'h0010; d_wmask = 4'b0100; d_wdata = 32'h00AB0000;
        do_cycle(gi, gd);
        n_tests++;
        if (gd !== 1'b1 || d_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL store: got gnt %b rvalid %b expected 1 0", gd, d_rvalid);
        end
        d_wmask = 4'b0;
        do_cycle(gi, gd);
        idle_reqs();
        n_tests++;
        if (d_rvalid !== 1'b1 || d_rdata[23:16] !== 8'hAB) begin
            n_fail++; $display("FAIL store_readback: got rvalid %b byte %h expected 1 ab", d_rvalid, d_rdata[23:16]);
        end
    endtask

    task automatic test_reset_mid();
        logic gi, gd;
        apply_reset();
        d_req = 1'b1; d_addr = 16'h0040; d_wmask = 4'b0;
        do_cycle(gi, gd);
        resetn = 1'b0; i_req = 1'b1; i_addr = 16'h0;
        do_cycle(gi, gd);
        n_tests++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || fetch_stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid: got rvalid %b%b stall %0d expected 00 0", i_rvalid, d_rvalid, fetch_stall_cnt);
        end
        do_cycle(gi, gd);
        resetn = 1'b1; d_req = 1'b0;
        do_cycle(gi, gd);
        i_req = 1'b0;
        n_tests++;
        if (gi !== 1'b1 || i_rvalid !== 1'b1 || i_rdata !== shadow[0]) begin
            n_fail++; $display("FAIL reset_mid_fetch: got %b %b %h expected 1 1 %h", gi, i_rvalid, i_rdata, shadow[0]);
        end
    endtask

    task automatic test_misaligned();
        logic gi, gd;
        logic [31:0] w7;
        apply_reset();
        i_req = 1'b1; i_addr = 16'h0007;
        do_cycle(gi, gd);
        w7 = i_rdata;
        i_addr = 16'h0004;
        do_cycle(gi, gd);
        i_req = 1'b0;
        n_tests++;
        if (w7 !== i_rdata || w7 !== shadow[1]) begin
            n_fail++; $display("FAIL misaligned: got %h expected %h", w7, shadow[1]);
        end
    endtask

    task automatic test_random();
        logic gi, gd;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if (!i_req && $urandom_range(0, 3) != 0) begin
                i_req  = 1'b1;
                i_addr = 16'({$urandom_range(0, 63), 2'b00} | $urandom_range(0, 3));
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req   = 1'b1;
                d_addr  = 16'({$urandom_range(0, 63), 2'b00} | $urandom_range(0, 3));
                d_wmask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
                d_wdata = $urandom;
            end
            if (n % 97 == 50) resetn = 1'b0;
            do_cycle(gi, gd);
            if (!resetn) begin
                resetn = 1'b1;
                idle_reqs();
            end
            if (gi) i_req = 1'b0;
            if (gd) d_req = 1'b0;
        end
        idle_reqs();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
        m_burst = 0; m_stall = 0; pend = 0; pdata = 32'h0;
        resetn = 1'b0; i_addr = 16'h0; d_addr = 16'h0;
        idle_reqs();
        @(posedge clk); #1;
        test_reset();
        test_fetch_seq();
        test_priority();
        test_burst();
        test_store();
        test_reset_mid();
        test_misaligned();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
